meter_countdown: RTL
====================

Name: meter_countdown

Overview:
- Parking-meter time-credit engine and producer of the four BCD digits consumed by the seven-segment display controller.
- Holds remaining seconds as 4 packed BCD digits, 0000..9999.
- Adds credit on coin pulses, loads presets, and decrements once per 1 Hz tick.
- Emits status flags: expired and low-time (blink request).

Parameters:
- MAX_VAL, 9999, saturation ceiling (decimal; converted to BCD at elaboration).
- LOW_THRESH, 180, low_time asserted when 0 < credit < LOW_THRESH.
- PRESET1_VAL, 15, value loaded by load1.
- PRESET2_VAL, 185, value loaded by load2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tick_1hz  in  1  single-cycle strobe, one per second
- add_60  in  1  single-cycle pulse, add 60 s
- add_120  in  1  single-cycle pulse, add 120 s
- add_180  in  1  single-cycle pulse, add 180 s
- add_300  in  1  single-cycle pulse, add 300 s
- load1  in  1  single-cycle pulse, load PRESET1_VAL
- load2  in  1  single-cycle pulse, load PRESET2_VAL
- digit3..digit0  out  4 each  registered BCD credit; digit3 = thousands
- expired  out  1  credit == 0
- low_time  out  1  0 < credit < LOW_THRESH
- blink_phase  out  1  toggles on each tick while low_time or expired; 0 otherwise

Behaviour:
- Reset (async assert, sync-style deassert handled upstream): digits = 0000, expired = 1, low_time = 0, blink_phase = 0.
- All outputs registered; an event at edge N is visible after edge N.
- Per-cycle priority:
  1. load2 > load1: load preset; ignore tick and adds that cycle.
  2. Otherwise one add, priority 300 > 180 > 120 > 60; lower-priority simultaneous adds are dropped.
     Sum = min(credit + amount, MAX_VAL), in BCD with per-digit carry.
  3. Then, if tick_1hz and the intermediate value is > 0, decrement by 1 with BCD borrow (e.g. 1000 -> 0999).
- Tick at 0000: no change; no wrap to 9999.
- Add and tick in the same cycle at 9999: 9999 -> 9998.
- Flags are computed from the next-state value, so they are coherent with the digits in the same cycle.
- blink_phase:
  - Toggles on each tick_1hz while the next-state value is < LOW_THRESH.
  - Forced to 0 when the next-state value is >= LOW_THRESH.
- Digits are always valid BCD; a non-BCD nibble is unreachable.

Optional Feature:
- METER_PAUSE_EN defined:
  - Adds input port pause (1 bit).
  - While pause = 1, tick_1hz is ignored: no decrement, no blink_phase toggle.
  - Adds and loads still apply.
- METER_PAUSE_EN undefined: no pause port; every tick is honoured.

Decomposition:
- Package meter_pkg holds:
  - bcd_digit_t (4 bits) and bcd4_t (4 x bcd_digit_t).
  - Add amounts 60/120/180/300 as BCD constants.
  - Decimal-to-BCD constant function.
  - BCD_ZERO constant.
- Sub-module meter_bcd_arith (combinational):
  - Inputs: bcd4_t value, bcd4_t addend, dec, sat_max.
  - Outputs: saturated sum, then conditional decrement.
  - Instantiated once.

Test Plan:
- Reset: assert rst_n = 0 mid-count at 0123 -> digits 0000, expired = 1, low_time = 0, blink_phase = 0 immediately (asynchronous).
- Add 300 then 5 ticks -> 0300 then 0295; low_time = 0; digit borrow verified at 0300 -> 0299.
- load1 then 15 ticks -> 0015 counting down to 0000; expired rises on the 15th tick; 16th tick keeps 0000; blink_phase toggles each tick.
- Credit 9900, add 300 -> 9999 (saturated); add_60 + tick in the same cycle -> 9998.
- add_60 and add_300 in the same cycle from 0000 -> 0300; load2 with add_180 and tick in the same cycle -> 0185, low_time = 0.
- Credit 0181, two ticks -> 0179; low_time asserts on the 0179 cycle; blink_phase begins toggling. With METER_PAUSE_EN and pause = 1, ticks leave 0179 unchanged.

Source files
------------

// File: rtl/meter_pkg.sv
// meter_pkg: shared types and constants for the parking-meter credit engine.
//   bcd_digit_t  - one packed BCD digit (0..9)
//   bcd4_t       - four BCD digits, index 3 = thousands, index 0 = units
//   BCD_ADD_*    - coin amounts expressed directly in BCD
//   dec_to_bcd   - elaboration-time decimal to BCD conversion for parameters
package meter_pkg;

    typedef logic [3:0] bcd_digit_t;
    typedef bcd_digit_t [3:0] bcd4_t;

    localparam bcd4_t BCD_ZERO    = 16'h0000;
    localparam bcd4_t BCD_ADD_60  = 16'h0060;
    localparam bcd4_t BCD_ADD_120 = 16'h0120;
    localparam bcd4_t BCD_ADD_180 = 16'h0180;
    localparam bcd4_t BCD_ADD_300 = 16'h0300;

    // Only meaningful for values 0..9999; higher digits are truncated.
    function automatic bcd4_t dec_to_bcd(input int unsigned val);
        bcd4_t       res;
        int unsigned rem;
        rem = val;
        for (int i = 0; i < 4; i++) begin
            res[i] = bcd_digit_t'(rem % 10);
            rem    = rem / 10;
        end
        return res;
    endfunction

endpackage

// File: rtl/meter_countdown_if.sv
// meter_countdown_if: control strobes and display/status outputs of the meter.
//   master - drives tick_1hz, add_60/120/180/300, load1/2 (and pause); reads digits/flags
//   slave  - the credit engine side
// Optional macro METER_PAUSE_EN adds the pause signal.
interface meter_countdown_if;
    import meter_pkg::*;

    logic       tick_1hz;
    logic       add_60;
    logic       add_120;
    logic       add_180;
    logic       add_300;
    logic       load1;
    logic       load2;
`ifdef METER_PAUSE_EN
    logic       pause;
`endif
    bcd_digit_t digit3;
    bcd_digit_t digit2;
    bcd_digit_t digit1;
    bcd_digit_t digit0;
    logic       expired;
    logic       low_time;
    logic       blink_phase;

    modport master (
`ifdef METER_PAUSE_EN
        output pause,
`endif
        output tick_1hz, add_60, add_120, add_180, add_300, load1, load2,
        input  digit3, digit2, digit1, digit0, expired, low_time, blink_phase
    );

    modport slave (
`ifdef METER_PAUSE_EN
        input  pause,
`endif
        input  tick_1hz, add_60, add_120, add_180, add_300, load1, load2,
        output digit3, digit2, digit1, digit0, expired, low_time, blink_phase
    );

endinterface

// File: rtl/meter_bcd_arith.sv
// meter_bcd_arith: combinational BCD add-with-saturation followed by an optional
// decrement with BCD borrow.
//   value   - current credit (BCD)
//   addend  - amount to add (BCD, zero when no coin)
//   dec     - decrement the saturated sum by one if it is nonzero
//   sat_max - saturation ceiling (BCD)
//   result  - min(value + addend, sat_max) - (dec && sum != 0)
module meter_bcd_arith
    import meter_pkg::*;
(
    input  bcd4_t value,
    input  bcd4_t addend,
    input  logic  dec,
    input  bcd4_t sat_max,
    output bcd4_t result
);

    bcd4_t      raw;
    bcd4_t      sum;
    logic       carry;
    logic       borrow;
    logic [4:0] dsum;

    always_comb begin
        carry = 1'b0;
        raw   = BCD_ZERO;
        dsum  = '0;
        for (int i = 0; i < 4; i++) begin
            dsum = {1'b0, value[i]} + {1'b0, addend[i]} + {4'b0000, carry};
            if (dsum > 5'd9) begin
                raw[i] = bcd_digit_t'(dsum - 5'd10);
                carry  = 1'b1;
            end else begin
                raw[i] = dsum[3:0];
                carry  = 1'b0;
            end
        end
        // BCD digit order matches numeric order, so a plain vector compare works.
        sum = (carry || (raw > sat_max)) ? sat_max : raw;
    end

    always_comb begin
        borrow = dec && (sum != BCD_ZERO);
        result = sum;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (sum[i] == 4'd0) begin
                    result[i] = 4'd9;
                end else begin
                    result[i] = sum[i] - 4'd1;
                    borrow    = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/meter_countdown.sv
// meter_countdown: parking-meter time-credit engine.
//   clk, rst_n - clock and asynchronous active-low reset
//   bus        - meter_countdown_if.slave: tick_1hz, coin adds, preset loads in;
//                BCD digits (digit3 = thousands), expired, low_time, blink_phase out
// Optional macro METER_PAUSE_EN: bus.pause masks tick_1hz (adds/loads still apply).
// All outputs are registered; flags are derived from the next-state credit so they
// line up with the digits on the same cycle.
module meter_countdown
    import meter_pkg::*;
#(
    parameter int unsigned MAX_VAL     = 9999,
    parameter int unsigned LOW_THRESH  = 180,
    parameter int unsigned PRESET1_VAL = 15,
    parameter int unsigned PRESET2_VAL = 185
) (
    input logic               clk,
    input logic               rst_n,
    meter_countdown_if.slave  bus
);

    localparam bcd4_t MAX_BCD     = dec_to_bcd(MAX_VAL);
    localparam bcd4_t LOW_BCD     = dec_to_bcd(LOW_THRESH);
    localparam bcd4_t PRESET1_BCD = dec_to_bcd(PRESET1_VAL);
    localparam bcd4_t PRESET2_BCD = dec_to_bcd(PRESET2_VAL);

    bcd4_t credit_q, credit_d;
    bcd4_t addend;
    bcd4_t arith_res;
    logic  expired_q, expired_d;
    logic  low_q, low_d;
    logic  blink_q, blink_d;
    logic  tick_ok;
    logic  loading;

`ifdef METER_PAUSE_EN
    assign tick_ok = bus.tick_1hz & ~bus.pause;
`else
    assign tick_ok = bus.tick_1hz;
`endif

    assign loading = bus.load1 | bus.load2;

    // Only the highest-priority coin counts; the others in the same cycle are lost.
    always_comb begin
        if (bus.add_300) begin
            addend = BCD_ADD_300;
        end else if (bus.add_180) begin
            addend = BCD_ADD_180;
        end else if (bus.add_120) begin
            addend = BCD_ADD_120;
        end else if (bus.add_60) begin
            addend = BCD_ADD_60;
        end else begin
            addend = BCD_ZERO;
        end
    end

    meter_bcd_arith u_arith (
        .value   (credit_q),
        .addend  (addend),
        .dec     (tick_ok),
        .sat_max (MAX_BCD),
        .result  (arith_res)
    );

    always_comb begin
        if (bus.load2) begin
            credit_d = PRESET2_BCD;
        end else if (bus.load1) begin
            credit_d = PRESET1_BCD;
        end else begin
            credit_d = arith_res;
        end

        expired_d = (credit_d == BCD_ZERO);
        low_d     = !expired_d && (credit_d < LOW_BCD);

        // A load swallows the tick, so it must not toggle the blink either.
        if (credit_d >= LOW_BCD) begin
            blink_d = 1'b0;
        end else if (tick_ok && !loading) begin
            blink_d = ~blink_q;
        end else begin
            blink_d = blink_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q  <= BCD_ZERO;
            expired_q <= 1'b1;
            low_q     <= 1'b0;
            blink_q   <= 1'b0;
        end else begin
            credit_q  <= credit_d;
            expired_q <= expired_d;
            low_q     <= low_d;
            blink_q   <= blink_d;
        end
    end

    assign bus.digit3      = credit_q[3];
    assign bus.digit2      = credit_q[2];
    assign bus.digit1      = credit_q[1];
    assign bus.digit0      = credit_q[0];
    assign bus.expired     = expired_q;
    assign bus.low_time    = low_q;
    assign bus.blink_phase = blink_q;

endmodule
